// File: rtl/t_seq_packer.sv
// Packs a 2-bit base stream into 18-bit T words (7 bases/word), buffers them, then streams them to the SRAM controller.
// Latency: start strobe 1 cycle after the last accepted base; word 0 preloaded before busy, one word per busy cycle.
// Backpressure: o_base_ready is high only while loading; it drops on the last base or when the buffer fills.
module t_seq_packer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_base_valid,
    input  logic [1:0]        i_base,
    input  logic              i_base_last,
    output logic              o_base_ready,
    output logic              o_start_read_t,
    input  logic              i_busy,
    output logic [17:0]       o_t,
    output logic [ADDR_W:0]   o_t_words,
    output logic              o_done
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    // Index of the final word slot; filling it without a last flag forces the end of the sequence.
    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

    logic [1:0]        state;
    logic [13:0]       pack;
    logic [2:0]        slot;
    logic [ADDR_W:0]   wcnt;
    logic [ADDR_W:0]   rd_ptr;
    logic [17:0]       mem [DEPTH];

    logic              accept;
    logic [3:0]        shamt;
    logic [13:0]       pack_nxt;
    logic              word_wr;
    logic              go_start;
    logic [17:0]       word_dat;
    logic [ADDR_W:0]   rd_nxt;
    logic [17:0]       rd_word;

    assign o_base_ready   = (state == S_LOAD);
    assign o_start_read_t = (state == S_START);
    assign o_t_words      = wcnt;

    // Pack the incoming base into its slot (base0 in the top bits) and decide word/sequence boundaries.
    always_comb begin
        accept   = i_base_valid & o_base_ready;
        shamt    = 4'd12 - {slot, 1'b0};
        pack_nxt = pack | (14'(i_base) << shamt);
        word_wr  = accept & (i_base_last | (slot == 3'd6));
        go_start = accept & (i_base_last | ((slot == 3'd6) & (wcnt == LAST_WORD)));
        word_dat = {1'b1, slot + 3'd1, pack_nxt};
        rd_nxt   = rd_ptr + 1'b1;
        rd_word  = (rd_nxt < wcnt) ? mem[rd_nxt[ADDR_W-1:0]] : 18'h0;
    end

    // Word buffer write port; contents need no reset since wcnt bounds every read.
    always_ff @(posedge clk) begin
        if (!rst && word_wr) begin
            mem[wcnt[ADDR_W-1:0]] <= word_dat;
        end
    end

    // Load / start / wait / stream sequencing with the registered T word output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LOAD;
            pack   <= '0;
            slot   <= '0;
            wcnt   <= '0;
            rd_ptr <= '0;
            o_t    <= '0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (accept) begin
                        if (word_wr) begin
                            pack <= '0;
                            slot <= '0;
                            wcnt <= wcnt + 1'b1;
                        end else begin
                            pack <= pack_nxt;
                            slot <= slot + 3'd1;
                        end
                        if (go_start) begin
                            state <= S_START;
                        end
                    end
                end
                S_START: begin
                    o_t   <= mem[{ADDR_W{1'b0}}];
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_busy) begin
                        o_t    <= rd_word;
                        rd_ptr <= rd_nxt;
                        state  <= S_STREAM;
                    end
                end
                default: begin
                    if (i_busy) begin
                        o_t <= rd_word;
                        if (rd_ptr < wcnt) begin
                            rd_ptr <= rd_nxt;
                        end
                    end else begin
                        o_done <= 1'b1;
                        state  <= S_LOAD;
                        pack   <= '0;
                        slot   <= '0;
                        wcnt   <= '0;
                        rd_ptr <= '0;
                        o_t    <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_seq_packer.sv
module tb_t_seq_packer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_base_valid;
    logic [1:0]        i_base;
    logic              i_base_last;
    logic              o_base_ready;
    logic              o_start_read_t;
    logic              i_busy;
    logic [17:0]       o_t;
    logic [ADDR_W:0]   o_t_words;
    logic              o_done;

    int checks = 0;
    int errors = 0;

    bit   [1:0]  bq[$];
    logic [17:0] exp_q[$];

    t_seq_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_base_valid   (i_base_valid),
        .i_base         (i_base),
        .i_base_last    (i_base_last),
        .o_base_ready   (o_base_ready),
        .o_start_read_t (o_start_read_t),
        .i_busy         (i_busy),
        .o_t            (o_t),
        .o_t_words      (o_t_words),
        .o_done         (o_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: cut the accepted bases into groups of seven, each group one word.
    function automatic void build_exp(input int acc);
        int cnt;
        logic [17:0] wd;
        exp_q.delete();
        for (int w = 0; w * 7 < acc; w++) begin
            cnt = acc - 7 * w;
            if (cnt > 7) cnt = 7;
            wd = 18'h20000 | (18'(cnt) << 14);
            for (int j = 0; j < cnt; j++)
                wd = wd | (18'(bq[7 * w + j]) << (12 - 2 * j));
            exp_q.push_back(wd);
        end
    endfunction

    function automatic logic [17:0] exp_word(input int k);
        return (k < exp_q.size()) ? exp_q[k] : 18'h0;
    endfunction

    function automatic void rand_bases(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(2'($urandom_range(0, 3)));
    endfunction

    // Offers bq; returns at the negedge of the start-strobe cycle.
    task automatic load_seq(input int n, input bit with_last, output int accepted);
        bit stopped;
        stopped  = 0;
        accepted = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            i_base_valid = 1'b1;
            i_base       = bq[i];
            i_base_last  = with_last && (i == n - 1);
            @(negedge clk);
            if (!o_base_ready) begin
                stopped = 1;
                break;
            end
            @(posedge clk); #1;
            accepted++;
        end
        if (!stopped) @(negedge clk);
        i_base_valid = 1'b0;
        i_base_last  = 1'b0;
        chk("start_pulse", 32'(o_start_read_t), 32'd1);
        chk("t_words", 32'(o_t_words), 32'(exp_q.size()));
        chk("ready_low_start", 32'(o_base_ready), 32'd0);
    endtask

    task automatic run_stream(input int hold, input int nbusy);
        @(negedge clk);
        chk("start_single", 32'(o_start_read_t), 32'd0);
        chk("wait_word0", 32'(o_t), 32'(exp_word(0)));
        for (int h = 0; h < hold; h++) begin
            i_base_valid = 1'b1;
            i_base       = 2'($urandom_range(0, 3));
            @(negedge clk);
            chk("hold_word0", 32'(o_t), 32'(exp_word(0)));
            chk("ready_wait", 32'(o_base_ready), 32'd0);
        end
        i_busy = 1'b1;
        for (int k = 0; k < nbusy; k++) begin
            i_base_valid = 1'b1;
            i_base       = 2'($urandom_range(0, 3));
            chk("stream_word", 32'(o_t), 32'(exp_word(k)));
            chk("ready_stream", 32'(o_base_ready), 32'd0);
            @(negedge clk);
        end
        i_busy       = 1'b0;
        i_base_valid = 1'b0;
        chk("done_early", 32'(o_done), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(o_done), 32'd1);
        chk("ready_after", 32'(o_base_ready), 32'd1);
        chk("words_clear", 32'(o_t_words), 32'd0);
        @(negedge clk);
        chk("done_once", 32'(o_done), 32'd0);
    endtask

    initial begin
        int acc;
        int n;
        int nb;
        rst = 1'b1;
        i_base_valid = 1'b0;
        i_base = 2'd0;
        i_base_last = 1'b0;
        i_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_base_ready), 32'd1);
        chk("rst_start", 32'(o_start_read_t), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_t", 32'(o_t), 32'd0);
        chk("rst_words", 32'(o_t_words), 32'd0);
        rst = 1'b0;

        // 14 bases, two full words; hold busy low 5 cycles in WAIT first.
        bq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        build_exp(14);
        chk("tp_word0", 32'(exp_q[0]), 32'h3C6C6);
        chk("tp_word1", 32'(exp_q[1]), 32'h3F1B1);
        load_seq(14, 1, acc);
        chk("acc14", 32'(acc), 32'd14);
        run_stream(5, 3);

        // Three bases, one partial word.
        bq = '{3, 3, 3};
        build_exp(3);
        chk("tp_partial", 32'(exp_q[0]), 32'h2FF00);
        load_seq(3, 1, acc);
        run_stream(0, 2);

        // Buffer fill: 30 offered, no last; only DEPTH*7 accepted.
        rand_bases(30);
        build_exp(DEPTH * 7);
        load_seq(30, 0, acc);
        chk("acc_full", 32'(acc), 32'(DEPTH * 7));
        run_stream(1, DEPTH + 1);

        // Reset while streaming.
        rand_bases(14);
        build_exp(14);
        load_seq(14, 1, acc);
        @(negedge clk);
        i_busy = 1'b1;
        @(negedge clk);
        chk("pre_rst_word1", 32'(o_t), 32'(exp_q[1]));
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_t", 32'(o_t), 32'd0);
        chk("mid_rst_words", 32'(o_t_words), 32'd0);
        chk("mid_rst_ready", 32'(o_base_ready), 32'd1);
        rst    = 1'b0;
        i_busy = 1'b0;
        rand_bases(7);
        build_exp(7);
        load_seq(7, 1, acc);
        run_stream(0, 2);

        // Random sequences, including busy dropping before all words are sent.
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, DEPTH * 7);
            rand_bases(n);
            build_exp(n);
            nb = $urandom_range(1, exp_q.size() + 2);
            load_seq(n, 1, acc);
            chk("acc_rand", 32'(acc), 32'(n));
            run_stream($urandom_range(0, 3), nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/t_seq_packer.md
# t_seq_packer

Upstream feeder for the SRAM controller's target-sequence load port. The block accepts the target sequence T one 2-bit base per cycle over a valid/ready stream. It packs seven bases into each 18-bit T word and buffers the whole sequence. It then pulses the controller's start-read strobe and presents one word per cycle on the controller's `i_t` input for as long as the controller holds `o_busy`.

## Interface
- `DEPTH`, default 64: word buffer depth; capacity is DEPTH×7 bases.
- `ADDR_W`, default 6: log2(DEPTH).

- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock, synchronous active-high reset: fixed.
- `i_base_valid`  in  1  base present on `i_base`.
- `i_base`  in  2  nucleotide code.
- `i_base_last`  in  1  qualifies the final base of the sequence.
- `o_base_ready`  out  1  a base is accepted on a cycle with valid&ready.
- `o_start_read_t`  out  1  one-cycle pulse; drives the controller's `i_start_read_t`.
- `i_busy`  in  1  the controller's `o_busy`.
- `o_t`  out  18  T word; drives the controller's `i_t`.
- `o_t_words`  out  ADDR_W+1  number of data words buffered (excludes the terminator).
- `o_done`  out  1  one-cycle pulse when the stream completes.

## Operation
- Word format:
  - [17] valid = 1.
  - [16:14] base count, 1..7; 7 for every non-final word.
  - [13:0] bases, base0 at [13:12], base6 at [1:0]; unused slots are 0.
- Terminator word is 18'h0 (valid = 0). The controller detects end of sequence by valid = 0.
- FSM states:
  - LOAD:
    - `o_base_ready` = 1.
    - Accepted bases fill a 14-bit shift/pack register and a 3-bit slot counter.
    - The 7th base writes the word to the buffer, increments the write pointer and clears the counter.
    - An accepted base with `i_base_last` writes the partial or full word with its count, then goes to START.
  - LOAD buffer full: when DEPTH full words are written without `i_base_last`, the last accepted base is treated as last, `o_base_ready` drops, and the FSM goes to START.
  - START:
    - `o_start_read_t` = 1 for exactly one cycle.
    - `o_t` is preloaded with word 0.
    - Next state is WAIT.
  - WAIT: holds word 0 on `o_t` until `i_busy` = 1, then goes to STREAM.
  - STREAM:
    - Each rising edge with `i_busy` = 1 advances the read pointer.
    - `o_t` becomes the next word, or 18'h0 once past the last word, and stays 0.
    - When `i_busy` falls: pulse `o_done`, clear pointers, counter and `o_t_words`, return to LOAD.
- `o_base_ready` = 0 in START, WAIT and STREAM. Bases offered there are not captured.
- Empty sequences cannot occur, because `i_base_last` always accompanies a base.

## Timing
- Reset values:
  - `o_base_ready` = 1; state LOAD.
  - `o_start_read_t` = 0, `o_done` = 0.
  - `o_t` = 18'h0, `o_t_words` = 0.
- `o_t` is registered. Word k is stable throughout the k-th cycle in which `i_busy` is sampled high (k from 0), so the controller samples word k on the k-th busy edge.
- `o_start_read_t` asserts the cycle after the accepted last base. Worst case is 1 cycle from the last base to the pulse.
- `o_t_words` is valid from START onward.
- `i_busy` low during STREAM before all words are sent: the stream ends anyway, with `o_done` and return to LOAD.
- A `rst` in any state returns every register to its reset value on the next edge, including while streaming.

## Test plan
- Load 14 bases 0,1,2,3,0,1,2,3,0,1,2,3,0,1 with last on the 14th, then raise busy for 3 cycles:
  - `o_start_read_t` pulses once.
  - `o_t_words` = 2.
  - `o_t` = 18'h3C6C6, 18'h3F1B1, then 18'h0.
- Load 3 bases 3,3,3 with last:
  - word 18'h2FF00, then terminator 18'h0.
  - `o_done` pulses the cycle after busy falls.
- After START, hold busy low 5 cycles → `o_t` holds word 0 and no pointer advances.
- With DEPTH=4, offer 30 bases with no last:
  - ready drops after the 28th base.
  - start pulse follows.
  - 4 words with count 7 stream, then 0.
- Assert `rst` mid-STREAM:
  - next cycle `o_t` = 0, `o_t_words` = 0, ready = 1.
  - a fresh 7-base load produces the correct single word.
- Offer bases during STREAM → ready stays 0 and none are captured. After `o_done`, a new load starts from an empty buffer.
